voter_session: RTL

Parametrised, sequential generalisation of the three-judge voter. Runs timed voting sessions for `N_VOTERS` judges: each judge's button input is debounced and latched once, the session closes when all have voted or a timeout expires, and the tally is compared against a configurable threshold. It drives active-low vote and result LEDs directly on the board, and exposes a binary vote count and status for the display logic.

---
 rtl/voter_session.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/voter_session.sv
// voter_session: timed multi-judge voting with per-button debounce,
// sticky vote latches, timeout/early close and a thresholded tally.
// LEDs are driven active-low; count/busy/done feed the display logic.
module voter_session #(
    parameter int unsigned N_VOTERS   = 3,
    parameter int unsigned THRESHOLD  = 2,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [N_VOTERS-1:0]              vote_in,
    output logic [N_VOTERS-1:0]              vote_led,
    output logic                             result_led,
    output logic [$clog2(N_VOTERS+1)-1:0]    count,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned CNT_W = $clog2(N_VOTERS + 1);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    // Reject parameter sets that make the session meaningless.
    if (N_VOTERS == 0) begin : g_chk_voters
        $error("voter_session: N_VOTERS must be at least 1");
    end
    if (THRESHOLD == 0 || THRESHOLD > N_VOTERS) begin : g_chk_threshold
        $error("voter_session: THRESHOLD must lie in 1..N_VOTERS");
    end
    if (DEB_CYCLES == 0) begin : g_chk_deb
        $error("voter_session: DEB_CYCLES must be at least 1");
    end
    if (TIMEOUT == 0) begin : g_chk_timeout
        $error("voter_session: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_TALLY,
        S_SHOW
    } state_t;

    state_t              state;
    logic [N_VOTERS-1:0] latch;
    logic [N_VOTERS-1:0] latch_nxt;
    logic [DEB_W-1:0]    deb_cnt [N_VOTERS];
    logic [DEB_W-1:0]    deb_nxt [N_VOTERS];
    logic [TMR_W-1:0]    timer;
    logic [CNT_W-1:0]    tally_c;
    logic                pass_c;
    logic                close_c;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(N_VOTERS); i++) begin
            acc = acc + CNT_W'(v[i]);
        end
        return acc;
    endfunction

    // Debounce: count consecutive high samples per open latch, set latch on the last one.
    always_comb begin
        latch_nxt = latch;
        for (int i = 0; i < int'(N_VOTERS); i++) begin
            deb_nxt[i] = deb_cnt[i];
            if (!latch[i]) begin
                if (vote_in[i]) begin
                    if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        latch_nxt[i] = 1'b1;
                    end
                    if (deb_cnt[i] != DEB_W'(DEB_CYCLES)) begin
                        deb_nxt[i] = deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_nxt[i] = '0;
                end
            end
        end
    end

    // Tally and close conditions, evaluated from the registered latches.
    always_comb begin
        tally_c = popcount(latch);
        pass_c  = (32'(tally_c) >= THRESHOLD);
        close_c = (&latch) || (timer == TMR_W'(TIMEOUT - 1));
    end

    // Session FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            latch      <= '0;
            timer      <= '0;
            for (int i = 0; i < int'(N_VOTERS); i++) begin
                deb_cnt[i] <= '0;
            end
            vote_led   <= '1;
            result_led <= 1'b1;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_SHOW: begin
                    if (start) begin
                        state      <= S_OPEN;
                        latch      <= '0;
                        timer      <= '0;
                        for (int i = 0; i < int'(N_VOTERS); i++) begin
                            deb_cnt[i] <= '0;
                        end
                        vote_led   <= '1;
                        result_led <= 1'b1;
                        count      <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_OPEN: begin
                    latch    <= latch_nxt;
                    vote_led <= ~latch_nxt;
                    for (int i = 0; i < int'(N_VOTERS); i++) begin
                        deb_cnt[i] <= deb_nxt[i];
                    end
                    timer <= timer + TMR_W'(1);
                    if (close_c) begin
                        state <= S_TALLY;
                    end
                end
                S_TALLY: begin
                    state      <= S_SHOW;
                    count      <= tally_c;
                    result_led <= ~pass_c;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
